sd_spi_arbiter: RTL and testbench
=================================

# sd_spi_arbiter

Owns the single SD-card SPI bus after power-on and shares it between three engines: the card-initialisation engine, a block-read engine and a block-write engine. The init engine owns the bus exclusively until it reports completion. After that, read and write requests are granted round-robin, with a fixed chip-select-high gap between owners. The block sits between the engines and the SD pins in the SD subsystem top level.

## Interface
Parameters:
- GAP_CYCLES, 16: clk_sd cycles of bus idle (cs=1, mosi=1, clk=1) inserted after every release.
- TIMEOUT_CYC, 5000000: watchdog limit per grant, in clk_sd cycles (100 ms at 50 MHz).

Ports:
- clk_sd  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- sd_spi_miso  in  1  card MISO, fanned out unchanged to all engines.
- sd_spi_clk  out  1  bus SPI clock.
- sd_spi_cs  out  1  bus chip select, active low.
- sd_spi_mosi  out  1  bus MOSI.
- init_spi_clk, init_spi_cs, init_spi_mosi  in  1 each  init engine bus drive.
- sd_init_done  in  1  init engine completion level.
- rd_req  in  1  read engine request, level.
- rd_gnt  out  1  read engine grant, registered.
- rd_done  in  1  read engine release, 1-cycle pulse.
- rd_spi_clk, rd_spi_cs, rd_spi_mosi  in  1 each  read engine bus drive.
- wr_req, wr_gnt, wr_done, wr_spi_clk, wr_spi_cs, wr_spi_mosi: same as the rd_ set, for the write engine.
- bus_ready  out  1  high once init has completed and the arbiter is in IDLE with no grant.
- arb_err  out  1  1-cycle pulse on watchdog release.

## Operation
States:
- INIT: bus muxed from the init engine. Registered sd_init_done=1 -> GAP.
- GAP: bus idle. Counts GAP_CYCLES, then -> IDLE.
- IDLE: bus idle. If rd_req or wr_req is high -> GRANT_RD or GRANT_WR per round-robin.
- GRANT_RD / GRANT_WR: bus muxed from the owner; owner gnt=1.
  - Owner done=1 -> GAP; gnt drops next cycle.
  - Watchdog expiry -> GAP with arb_err pulse.

Rules:
- Round-robin: a 1-bit last_served register; reset value WR, so RD wins the first tie. A single requester is granted regardless of last_served. last_served updates on entry to a GRANT state.
- The mux select is a registered owner field. Engine bus signals pass combinationally to the pins, with zero added latency, while owned.
- Requesters must drop req in the same cycle as done, or earlier. A req still high on exit from GAP is treated as a new request.
- done from a non-owner is ignored. req is ignored in INIT and GAP.
- sd_init_done is sampled only in INIT. Later deassertion is ignored; re-init requires reset.
- done and watchdog expiry in the same cycle: treated as done, no arb_err.

## Timing
- Reset values: state=INIT, rd_gnt=0, wr_gnt=0, arb_err=0, bus_ready=0, last_served=WR, counters=0.
  - During reset and in INIT, the bus carries the init_spi_* inputs.
- sd_init_done rises at cycle N -> GAP entered at N+1 -> IDLE at N+1+GAP_CYCLES -> bus_ready=1 the same cycle.
- Request latency: req sampled high in IDLE at cycle N -> gnt=1 and bus muxed at N+1.
- Release: done at cycle M -> gnt=0 and bus idle at M+1.
  - Earliest next grant is M+2+GAP_CYCLES if req is held; M+1+GAP_CYCLES is the first IDLE cycle.
- Gap counter: 16-bit, clears on GAP entry. GAP_CYCLES=0 means GAP lasts 1 cycle.
- Watchdog: 24-bit counter, clears on GRANT entry, increments each granted cycle.
  - Count reaching TIMEOUT_CYC-1 forces release on the next edge.
  - arb_err is high for exactly the cycle gnt drops.
- Reset asserted mid-grant: next edge gives gnt=0, state=INIT, no arb_err.

## Configuration
- SD_ARB_WATCHDOG_EN defined: watchdog counter and arb_err logic as above.
- Undefined: no watchdog counter; grants end only on done or reset; arb_err is tied 0.

## Test plan
- Init handoff: reset, drive init_spi_cs=0 and toggle init_spi_clk -> pins follow exactly. Raise sd_init_done -> cs=1 for 16 cycles, then bus_ready=1.
- Simultaneous request: rd_req=wr_req=1 in the same IDLE cycle -> rd_gnt=1 next cycle. Pulse rd_done and drop rd_req -> after 16 gap cycles, wr_gnt=1 with wr_spi_* on the pins.
- Single requester twice: wr_req twice in a row with rd idle -> wr granted both times, gap of 16 between.
- Foreign done: pulse wr_done while rd owns the bus -> no state change, rd_gnt stays 1.
- Watchdog (macro on, TIMEOUT_CYC=100): hold rd_gnt without done -> at grant cycle 100, rd_gnt=0 and arb_err=1 for one cycle. Macro off -> grant holds past 1000 cycles.
- Reset mid-grant: assert reset while wr_gnt=1 -> next edge wr_gnt=0, pins carry init_spi_*, bus_ready=0.

Source files
------------

// File: rtl/sd_spi_arbiter.sv
// SD-card SPI bus arbiter: init engine owns the bus until sd_init_done, then
// read/write engines share it round-robin with a cs-high gap after each release.
// Optional watchdog per grant is enabled by defining SD_ARB_WATCHDOG_EN.
module sd_spi_arbiter #(
  parameter int GAP_CYCLES  = 16,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic       clk_sd,
  input  logic       reset,
  input  logic       sd_spi_miso,
  output logic       sd_spi_clk,
  output logic       sd_spi_cs,
  output logic       sd_spi_mosi,
  input  logic       init_spi_clk,
  input  logic       init_spi_cs,
  input  logic       init_spi_mosi,
  input  logic       sd_init_done,
  input  logic       rd_req,
  output logic       rd_gnt,
  input  logic       rd_done,
  input  logic       rd_spi_clk,
  input  logic       rd_spi_cs,
  input  logic       rd_spi_mosi,
  input  logic       wr_req,
  output logic       wr_gnt,
  input  logic       wr_done,
  input  logic       wr_spi_clk,
  input  logic       wr_spi_cs,
  input  logic       wr_spi_mosi,
  output logic       bus_ready,
  output logic       arb_err,
  output logic [2:0] arb_state
);

  // Handshake: req is a level held until (or dropped with) done; gnt is a
  // registered level that rises one cycle after req is seen in IDLE; done is a
  // one-cycle pulse from the current owner only, and gnt falls on the next edge.
  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_GAP      = 3'd1,
    ST_IDLE     = 3'd2,
    ST_GRANT_RD = 3'd3,
    ST_GRANT_WR = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OWN_INIT = 2'd0,
    OWN_NONE = 2'd1,
    OWN_RD   = 2'd2,
    OWN_WR   = 2'd3
  } owner_t;

  localparam logic LS_RD = 1'b0;
  localparam logic LS_WR = 1'b1;

  state_t      state, state_nxt;
  owner_t      owner, owner_nxt;
  logic [15:0] gap_cnt;
  logic        last_served;
  logic        gap_last;
  logic        wd_expire;
  logic        err_nxt;
  logic        unused_miso;

  // The card's MISO goes straight to the engines outside this block.
  assign unused_miso = sd_spi_miso;

  // GAP_CYCLES=0 still yields one GAP cycle because the check is made in GAP.
  assign gap_last = (({1'b0, gap_cnt} + 17'd1) >= 17'(GAP_CYCLES));

`ifdef SD_ARB_WATCHDOG_EN
  localparam logic [23:0] WD_LIMIT = 24'(TIMEOUT_CYC - 1);
  logic [23:0] wd_cnt;

  always_ff @(posedge clk_sd) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if ((state == ST_GRANT_RD && state_nxt == ST_GRANT_RD) ||
                 (state == ST_GRANT_WR && state_nxt == ST_GRANT_WR)) begin
      wd_cnt <= wd_cnt + 24'd1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_expire = (wd_cnt == WD_LIMIT);
`else
  logic unused_wd;
  assign unused_wd = (TIMEOUT_CYC != 0);
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      ST_INIT: if (sd_init_done) state_nxt = ST_GAP;
      ST_GAP:  if (gap_last) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (rd_req && (!wr_req || last_served == LS_WR)) state_nxt = ST_GRANT_RD;
        else if (wr_req)                                 state_nxt = ST_GRANT_WR;
      end
      ST_GRANT_RD: begin
        if (rd_done) begin
          state_nxt = ST_GAP;
        end else if (wd_expire) begin
          state_nxt = ST_GAP;
          err_nxt   = 1'b1;
        end
      end
      ST_GRANT_WR: begin
        if (wr_done) begin
          state_nxt = ST_GAP;
        end else if (wd_expire) begin
          state_nxt = ST_GAP;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    case (state_nxt)
      ST_INIT:     owner_nxt = OWN_INIT;
      ST_GRANT_RD: owner_nxt = OWN_RD;
      ST_GRANT_WR: owner_nxt = OWN_WR;
      default:     owner_nxt = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk_sd) begin
    if (reset) begin
      state       <= ST_INIT;
      owner       <= OWN_INIT;
      rd_gnt      <= 1'b0;
      wr_gnt      <= 1'b0;
      arb_err     <= 1'b0;
      last_served <= LS_WR;
      gap_cnt     <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      rd_gnt  <= (state_nxt == ST_GRANT_RD);
      wr_gnt  <= (state_nxt == ST_GRANT_WR);
      arb_err <= err_nxt;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 16'd1 : 16'd0;
      if (state_nxt == ST_GRANT_RD && state != ST_GRANT_RD) last_served <= LS_RD;
      if (state_nxt == ST_GRANT_WR && state != ST_GRANT_WR) last_served <= LS_WR;
    end
  end

  // reset overrides the owner register so the init engine drives the pins
  // even before the first clock edge of reset.
  always_comb begin
    sd_spi_clk  = 1'b1;
    sd_spi_cs   = 1'b1;
    sd_spi_mosi = 1'b1;
    if (reset || owner == OWN_INIT) begin
      sd_spi_clk  = init_spi_clk;
      sd_spi_cs   = init_spi_cs;
      sd_spi_mosi = init_spi_mosi;
    end else if (owner == OWN_RD) begin
      sd_spi_clk  = rd_spi_clk;
      sd_spi_cs   = rd_spi_cs;
      sd_spi_mosi = rd_spi_mosi;
    end else if (owner == OWN_WR) begin
      sd_spi_clk  = wr_spi_clk;
      sd_spi_cs   = wr_spi_cs;
      sd_spi_mosi = wr_spi_mosi;
    end
  end

  assign bus_ready = (state == ST_IDLE);
  assign arb_state = state;

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Directed bench for sd_spi_arbiter: init handoff, round-robin, gaps,
// foreign done, watchdog (or its absence) and reset during a grant.
module tb_sd_spi_arbiter;

  logic       clk_sd = 1'b0;
  logic       reset;
  logic       sd_spi_miso;
  logic       sd_spi_clk, sd_spi_cs, sd_spi_mosi;
  logic       init_spi_clk, init_spi_cs, init_spi_mosi;
  logic       sd_init_done;
  logic       rd_req, rd_gnt, rd_done, rd_spi_clk, rd_spi_cs, rd_spi_mosi;
  logic       wr_req, wr_gnt, wr_done, wr_spi_clk, wr_spi_cs, wr_spi_mosi;
  logic       bus_ready, arb_err;
  logic [2:0] arb_state;

  int total = 0;
  int bad   = 0;

  logic [2:0] init_vec [4] = '{3'b001, 3'b101, 3'b000, 3'b110};

  sd_spi_arbiter #(.GAP_CYCLES(16), .TIMEOUT_CYC(100)) dut (
    .clk_sd(clk_sd), .reset(reset), .sd_spi_miso(sd_spi_miso),
    .sd_spi_clk(sd_spi_clk), .sd_spi_cs(sd_spi_cs), .sd_spi_mosi(sd_spi_mosi),
    .init_spi_clk(init_spi_clk), .init_spi_cs(init_spi_cs), .init_spi_mosi(init_spi_mosi),
    .sd_init_done(sd_init_done),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_done(rd_done),
    .rd_spi_clk(rd_spi_clk), .rd_spi_cs(rd_spi_cs), .rd_spi_mosi(rd_spi_mosi),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .wr_spi_clk(wr_spi_clk), .wr_spi_cs(wr_spi_cs), .wr_spi_mosi(wr_spi_mosi),
    .bus_ready(bus_ready), .arb_err(arb_err), .arb_state(arb_state)
  );

  // clock / reset
  always #5 clk_sd = ~clk_sd;

  task automatic step();
    @(posedge clk_sd);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // pins as {clk, cs, mosi}, sampled after combinational settle
  task automatic chk_pins(input string tag, input logic [2:0] exp);
    #1;
    chk_vec(tag, {sd_spi_clk, sd_spi_cs, sd_spi_mosi}, exp);
  endtask

  initial begin
    reset = 1'b1; sd_spi_miso = 1'b0; sd_init_done = 1'b0;
    init_spi_clk = 1'b0; init_spi_cs = 1'b0; init_spi_mosi = 1'b1;
    rd_req = 1'b0; rd_done = 1'b0; rd_spi_clk = 1'b0; rd_spi_cs = 1'b0; rd_spi_mosi = 1'b0;
    wr_req = 1'b0; wr_done = 1'b0; wr_spi_clk = 1'b1; wr_spi_cs = 1'b0; wr_spi_mosi = 1'b1;

    // reset state
    step(); step();
    chk_bit("rst_rd_gnt", rd_gnt, 1'b0);
    chk_bit("rst_wr_gnt", wr_gnt, 1'b0);
    chk_bit("rst_arb_err", arb_err, 1'b0);
    chk_bit("rst_bus_ready", bus_ready, 1'b0);
    chk_vec("rst_state", arb_state, 3'd0);
    chk_pins("rst_pins_init", 3'b001);
    reset = 1'b0;
    step();
    chk_vec("init_state", arb_state, 3'd0);

    // init engine drives pins directly
    for (int i = 0; i < 4; i++) begin
      {init_spi_clk, init_spi_cs, init_spi_mosi} = init_vec[i];
      chk_pins("init_follow", init_vec[i]);
      step();
    end

    // handoff: 16 idle-bus gap cycles then bus_ready
    {init_spi_clk, init_spi_cs, init_spi_mosi} = 3'b000;
    sd_init_done = 1'b1;
    step();
    chk_vec("gap_entry_state", arb_state, 3'd1);
    for (int i = 0; i < 16; i++) begin
      chk_pins("gap_pins_idle", 3'b111);
      chk_bit("gap_not_ready", bus_ready, 1'b0);
      step();
    end
    chk_vec("idle_state", arb_state, 3'd2);
    chk_bit("idle_bus_ready", bus_ready, 1'b1);
    chk_pins("idle_pins", 3'b111);
    sd_init_done = 1'b0;

    // simultaneous request: rd wins first tie
    rd_req = 1'b1; wr_req = 1'b1;
    step();
    chk_bit("tie_rd_gnt", rd_gnt, 1'b1);
    chk_bit("tie_wr_gnt", wr_gnt, 1'b0);
    chk_bit("tie_not_ready", bus_ready, 1'b0);
    chk_pins("tie_rd_pins", 3'b000);
    rd_spi_clk = 1'b1;
    chk_pins("rd_clk_follow", 3'b100);

    // foreign done ignored
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    chk_bit("foreign_rd_gnt", rd_gnt, 1'b1);
    chk_vec("foreign_state", arb_state, 3'd3);

    // rd release, wr follows after gap
    rd_done = 1'b1; rd_req = 1'b0;
    step();
    rd_done = 1'b0;
    chk_bit("rel_rd_gnt", rd_gnt, 1'b0);
    chk_vec("rel_state_gap", arb_state, 3'd1);
    chk_pins("rel_pins_idle", 3'b111);
    repeat (16) step();
    chk_vec("rel_idle_state", arb_state, 3'd2);
    chk_bit("rel_wr_wait", wr_gnt, 1'b0);
    chk_bit("rel_bus_ready", bus_ready, 1'b1);
    step();
    chk_bit("wr_gnt_after_gap", wr_gnt, 1'b1);
    chk_bit("wr_no_rd_gnt", rd_gnt, 1'b0);
    chk_pins("wr_pins", 3'b101);

    // single requester twice (last_served=WR already)
    wr_done = 1'b1; wr_req = 1'b0;
    step();
    wr_done = 1'b0;
    chk_bit("wr_rel1", wr_gnt, 1'b0);
    wr_req = 1'b1;
    repeat (16) step();
    chk_bit("wr_gap2_no_gnt", wr_gnt, 1'b0);
    step();
    chk_bit("wr_second_gnt", wr_gnt, 1'b1);

    // rd alone, then tie with last_served=RD -> wr wins
    wr_done = 1'b1; wr_req = 1'b0;
    step();
    wr_done = 1'b0;
    rd_req = 1'b1;
    repeat (16) step();
    step();
    chk_bit("rd_single_gnt", rd_gnt, 1'b1);
    rd_done = 1'b1; rd_req = 1'b0;
    step();
    rd_done = 1'b0;
    rd_req = 1'b1; wr_req = 1'b1;
    repeat (16) step();
    step();
    chk_bit("tie2_wr_gnt", wr_gnt, 1'b1);
    chk_bit("tie2_rd_gnt", rd_gnt, 1'b0);

    // rd grant for watchdog test
    wr_done = 1'b1; wr_req = 1'b0;
    step();
    wr_done = 1'b0;
    repeat (16) step();
    step();
    chk_bit("wd_grant", rd_gnt, 1'b1);
`ifdef SD_ARB_WATCHDOG_EN
    repeat (99) step();
    chk_bit("wd_hold_99", rd_gnt, 1'b1);
    chk_bit("wd_no_err_99", arb_err, 1'b0);
    step();
    chk_bit("wd_drop", rd_gnt, 1'b0);
    chk_bit("wd_err", arb_err, 1'b1);
    chk_vec("wd_state_gap", arb_state, 3'd1);
    rd_req = 1'b0; wr_req = 1'b1;
    step();
    chk_bit("wd_err_pulse", arb_err, 1'b0);
    repeat (15) step();
`else
    repeat (1000) step();
    chk_bit("nowd_hold", rd_gnt, 1'b1);
    chk_bit("nowd_no_err", arb_err, 1'b0);
    rd_done = 1'b1; rd_req = 1'b0;
    step();
    rd_done = 1'b0;
    chk_bit("nowd_rel", rd_gnt, 1'b0);
    chk_bit("nowd_rel_err", arb_err, 1'b0);
    wr_req = 1'b1;
    repeat (16) step();
`endif
    chk_vec("post_wd_idle", arb_state, 3'd2);
    chk_bit("post_wd_ready", bus_ready, 1'b1);
    step();
    chk_bit("pre_reset_wr_gnt", wr_gnt, 1'b1);

    // reset mid-grant
    {init_spi_clk, init_spi_cs, init_spi_mosi} = 3'b010;
    reset = 1'b1;
    step();
    chk_bit("mid_rst_wr_gnt", wr_gnt, 1'b0);
    chk_bit("mid_rst_arb_err", arb_err, 1'b0);
    chk_bit("mid_rst_ready", bus_ready, 1'b0);
    chk_vec("mid_rst_state", arb_state, 3'd0);
    chk_pins("mid_rst_pins", 3'b010);
    reset = 1'b0;
    step();
    chk_vec("post_rst_init", arb_state, 3'd0);
    chk_bit("post_rst_req_ignored", wr_gnt, 1'b0);
    chk_pins("post_rst_pins", 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
